// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_hazard_controller
// Purpose  : Hazard control for a simple in-order pipeline. Handles taken-
//            branch flushes (two EX bubbles), multi-cycle ALU operations
//            (front-end stall while the op occupies EX) and load-use stalls
//            (one-cycle stall with an EX bubble). Also counts PC stall cycles.
// Ports    : clk, rst_n               clock / async active-low reset
//            id_valid, id_rs1/2,      ID-stage instruction and source usage
//            id_use_rs1/2
//            ex_valid, ex_is_load,    EX-stage instruction description
//            ex_rd, ex_aluOp
//            branch_taken             EX resolves a taken branch
//            pc_stall, fd_stall       hold PC / Fetch-Decode register
//            fd_flush                 bubble into Fetch-Decode
//            de_enable, de_flush      Decode-Execute load enable / bubble
//            busy                     multi-cycle op in progress
//            state                    FSM state (RUN=0, MULTI=1, FLUSH=2)
//            stall_count              saturating count of pc_stall cycles
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller #(
  parameter logic [3:0] MULTI_OP  = 4'b1100,
  parameter int         MULTI_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        id_valid,
  input  logic [3:0]  id_rs1,
  input  logic [3:0]  id_rs2,
  input  logic        id_use_rs1,
  input  logic        id_use_rs2,
  input  logic        ex_valid,
  input  logic        ex_is_load,
  input  logic [3:0]  ex_rd,
  input  logic [3:0]  ex_aluOp,
  input  logic        branch_taken,
  output logic        pc_stall,
  output logic        fd_stall,
  output logic        fd_flush,
  output logic        de_enable,
  output logic        de_flush,
  output logic        busy,
  output logic [1:0]  state,
  output logic [15:0] stall_count
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MULTI = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // The cycle that launches the op already stalls, and the counter==0 cycle
  // releases the stall, so the counter starts two below the latency.
  localparam logic [3:0] COUNT_LOAD = 4'(MULTI_LAT - 2);

  state_t     cur_state;
  state_t     next_state;
  logic [3:0] count;
  logic [3:0] count_next;

  logic load_use;
  logic multi_start;

  // Register 0 is hardwired zero, so it never creates a dependency.
  assign load_use = ex_valid && ex_is_load && (ex_rd != 4'd0) && id_valid &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign multi_start = ex_valid && (ex_aluOp == MULTI_OP);

  always_comb begin
    pc_stall   = 1'b0;
    fd_stall   = 1'b0;
    fd_flush   = 1'b0;
    de_enable  = 1'b1;
    de_flush   = 1'b0;
    busy       = 1'b0;
    next_state = cur_state;
    count_next = count;

    case (cur_state)
      RUN: begin
        if (branch_taken) begin
          fd_flush   = 1'b1;
          de_flush   = 1'b1;
          next_state = FLUSH;
        end else if (multi_start) begin
          pc_stall   = 1'b1;
          fd_stall   = 1'b1;
          de_enable  = 1'b0;
          busy       = 1'b1;
          count_next = COUNT_LOAD;
          next_state = MULTI;
        end else if (load_use) begin
          // Hold the front end and squash the dependent op for one cycle.
          pc_stall = 1'b1;
          fd_stall = 1'b1;
          de_flush = 1'b1;
        end
      end

      MULTI: begin
        busy = 1'b1;
        if (count != 4'd0) begin
          pc_stall   = 1'b1;
          fd_stall   = 1'b1;
          de_enable  = 1'b0;
          count_next = count - 4'd1;
        end else begin
          next_state = RUN;
        end
      end

      FLUSH: begin
        // Second bubble of a taken branch; everything else is ignored.
        de_flush   = 1'b1;
        next_state = RUN;
      end

      default: begin
        next_state = RUN;
      end
    endcase

    // Outputs are forced idle for the whole time reset is asserted, even if
    // the inputs would otherwise request a flush or stall in RUN.
    if (!rst_n) begin
      pc_stall  = 1'b0;
      fd_stall  = 1'b0;
      fd_flush  = 1'b0;
      de_enable = 1'b1;
      de_flush  = 1'b0;
      busy      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_state <= RUN;
      count     <= 4'd0;
    end else begin
      cur_state <= next_state;
      count     <= count_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= 16'd0;
    end else if (pc_stall && (stall_count != 16'hFFFF)) begin
      stall_count <= stall_count + 16'd1;
    end
  end

  assign state = cur_state;

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_controller.md
PIPELINE_HAZARD_CONTROLLER -- requirements
Module: pipeline_hazard_controller

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter MULTI_OP, default 4'b1100: aluOp code of the multi-cycle ALU operation.
REQ-003 Parameter MULTI_LAT, default 4: number of cycles a MULTI_OP occupies EX; legal range 2..15.
REQ-004 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock, rising edge
- rst_n  in  1  async reset, active-low
- id_valid  in  1  ID holds a real instruction
- id_rs1, id_rs2  in  4 each  ID source register indices
- id_use_rs1, id_use_rs2  in  1 each  ID reads rs1 / rs2
- ex_valid  in  1  EX holds a real instruction
- ex_is_load  in  1  EX instruction is a load
- ex_rd  in  4  EX destination register index
- ex_aluOp  in  4  aluOp currently in EX (DecodeExecute output)
- branch_taken  in  1  EX resolves a taken branch this cycle
- pc_stall  out  1  hold PC
- fd_stall  out  1  hold Fetch/Decode register
- fd_flush  out  1  load a bubble into Fetch/Decode
- de_enable  out  1  DecodeExecute register loads this edge
- de_flush  out  1  DecodeExecute loads a bubble (aluOp 0, srcA/srcB 0); overrides the data inputs when de_enable=1
- busy  out  1  multi-cycle op in progress
- state  out  2  FSM state: RUN=0, MULTI=1, FLUSH=2
- stall_count  out  16  saturating count of pc_stall cycles

Function
REQ-005 The FSM SHALL have exactly three states, RUN, MULTI and FLUSH; encoding 3 is unreachable and SHALL return to RUN.
REQ-006 Outputs SHALL be combinational from the state, the counter and the inputs; the state, the counter and stall_count SHALL be registered.
REQ-007 Idle outputs (no event) SHALL be pc_stall=0, fd_stall=0, fd_flush=0, de_enable=1, de_flush=0, busy=0.
REQ-008 The flush condition in RUN is branch_taken=1. It SHALL drive fd_flush=1, de_flush=1 and de_enable=1, and the next state SHALL be FLUSH.
REQ-009 In FLUSH the block SHALL drive de_flush=1, de_enable=1 and fd_flush=0, ignore all other inputs, and go to RUN next. A flush therefore yields two EX bubbles.
REQ-010 The multi-cycle condition in RUN is ex_valid=1, ex_aluOp=MULTI_OP and branch_taken=0. It SHALL drive pc_stall=1, fd_stall=1, de_enable=0 and busy=1, load the counter with MULTI_LAT-2, and go to MULTI next.
REQ-011 In MULTI with counter≠0 the block SHALL drive pc_stall=1, fd_stall=1, de_enable=0 and busy=1, and decrement the counter.
REQ-012 In MULTI with counter=0 the block SHALL drive the idle outputs except busy=1, and go to RUN next. Total stall is MULTI_LAT-1 cycles; the op occupies EX for MULTI_LAT cycles.
REQ-013 The load-use condition in RUN holds when all of the following are true: ex_valid=1, ex_is_load=1, ex_rd≠0, id_valid=1, and ((id_use_rs1 and id_rs1=ex_rd) or (id_use_rs2 and id_rs2=ex_rd)).
REQ-014 The load-use condition SHALL drive pc_stall=1, fd_stall=1, de_enable=1 and de_flush=1 for exactly that cycle, and the state SHALL remain RUN.
REQ-015 Priority in RUN SHALL be flush > multi-cycle > load-use; only the winning condition's outputs are driven.
REQ-016 Register index 0 SHALL never cause a load-use stall.
REQ-017 stall_count SHALL increment on every rising edge where pc_stall=1, and SHALL saturate at 16'hFFFF without wrapping.
REQ-018 branch_taken SHALL be ignored in MULTI and FLUSH.

Reset
REQ-019 While rst_n=0, asynchronously: state=RUN, counter=0, stall_count=0, and the outputs SHALL equal the idle values (de_enable=1, all others 0).
REQ-020 Reset asserted mid-MULTI or mid-FLUSH SHALL abort the operation immediately.
REQ-021 The first rising edge after rst_n deasserts SHALL evaluate in RUN.

Verification
REQ-022 Multi-cycle op: RUN, ex_valid=1, ex_aluOp=4'b1100, MULTI_LAT=4 -> pc_stall high 3 cycles, busy high 4 cycles, state 0→1→1→1→0, stall_count=3.
REQ-023 Load-use: ex_is_load=1, ex_rd=5, id_rs2=5, id_use_rs2=1 -> one cycle with pc_stall=1 and de_flush=1, state stays 0; with ex_rd=0 -> no stall.
REQ-024 Taken branch: branch_taken=1 in RUN -> fd_flush=1 and de_flush=1 in cycle 0; state=2 with de_flush=1 and fd_flush=0 in cycle 1; state=0 in cycle 2.
REQ-025 Simultaneous events: branch_taken=1 together with a load-use match -> flush outputs only, pc_stall=0, stall_count unchanged.
REQ-026 Reset mid-MULTI: rst_n=0 with counter=1 -> state=0, busy=0, de_enable=1 and stall_count=0 without waiting for a clock edge.
REQ-027 Saturation: force 65536 or more stall cycles -> stall_count holds 16'hFFFF and does not wrap.
